nc_cmd_sequencer: RTL

//  Command sequencer between the UART byte interface and the matrix-multiply datapath of the neural core.

---
 rtl/nc_pkg.sv | 24 ++
 rtl/nc_timeout_counter.sv | 19 +
 rtl/nc_cmd_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/nc_pkg.sv
// nc_pkg: opcodes, FSM state encoding and size helpers shared by the neural-core command path
package nc_pkg;
  localparam logic [7:0] OP_LOAD_A = 8'hA1;
  localparam logic [7:0] OP_LOAD_B = 8'hB1;
  localparam logic [7:0] OP_RUN    = 8'hC1;
  localparam logic [7:0] OP_READ   = 8'hD1;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_FETCH = 3'd4,
    S_SEND  = 3'd5
  } state_t;
  function automatic int idx_w(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction
  function automatic int nb_of(input int acc_w);
    return acc_w / 8;
  endfunction
  function automatic logic is_op(input logic [7:0] b);
    return b inside {OP_LOAD_A, OP_LOAD_B, OP_RUN, OP_READ};
  endfunction
endpackage

// File: rtl/nc_timeout_counter.sv
// nc_timeout_counter: idle-cycle counter that pulses expire when it reaches TIMEOUT-1
module nc_timeout_counter #(
  parameter int W = 24,
  parameter logic [W-1:0] TIMEOUT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  // a clear or a disable always wins over expiry, so a byte in the expiry cycle is never lost
  assign expire = en && !clr && cnt == TIMEOUT - 1'b1;
  // count idle cycles only while enabled; restart after every clear or expiry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/nc_cmd_sequencer.sv
// nc_cmd_sequencer: UART command parser driving operand loads, multiplier start and result readout
module nc_cmd_sequencer
  import nc_pkg::*;
#(
  parameter int DIM = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W = 16,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000,
  localparam int NE = DIM * DIM,
  localparam int AW = idx_w(DIM),
  localparam int NB = nb_of(ACC_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mult_start,
  input  logic              mult_done,
  output logic [AW-1:0]     res_addr,
  input  logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic              err
);
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST = AW'(NE - 1);
  state_t state, next;
  logic [AW-1:0] idx;
  logic [ACC_W-1:0] shift;
  logic [CW-1:0] cnt;
  logic last, expire;
  nc_timeout_counter #(.W(24), .TIMEOUT(TIMEOUT)) u_to (
    .clk(clk), .rst_n(rst_n), .clr(rx_valid), .en(state == S_LOAD), .expire(expire)
  );
  assign busy = state != S_IDLE;
  assign state_o = state;
  assign mult_start = state == S_RUN;
  assign tx_valid = state == S_SEND;
  assign tx_data = shift[ACC_W-1 -: 8];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  // next-state: opcodes decoded only in IDLE, bytes elsewhere are dropped
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  next = !rx_valid ? S_IDLE :
                      (rx_data == OP_LOAD_A || rx_data == OP_LOAD_B) ? S_LOAD :
                      rx_data == OP_RUN ? S_RUN :
                      rx_data == OP_READ ? S_FETCH : S_IDLE;
      S_LOAD:  next = ((rx_valid && idx == LAST) || expire) ? S_IDLE : S_LOAD;
      S_RUN:   next = S_WAIT;
      S_WAIT:  next = mult_done ? S_IDLE : S_WAIT;
      S_FETCH: next = S_SEND;
      S_SEND:  next = (tx_ready && cnt == CW'(NB - 1)) ? (last ? S_IDLE : S_FETCH) : S_SEND;
      default: next = S_IDLE;
    endcase
  end
  // datapath: operand writes, error pulse and result shifter; res_addr is advanced in FETCH
  // so the synchronous result read for the next element is already settled by the next FETCH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we <= 1'b0;
      mem_sel <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
      idx <= '0;
      res_addr <= '0;
      shift <= '0;
      cnt <= '0;
      last <= 1'b0;
    end else begin
      mem_we <= state == S_LOAD && rx_valid;
      err <= (state == S_IDLE && rx_valid && !is_op(rx_data)) || expire;
      if (state == S_IDLE) idx <= '0;
      if (state == S_IDLE && rx_valid && (rx_data == OP_LOAD_A || rx_data == OP_LOAD_B))
        mem_sel <= rx_data == OP_LOAD_B;
      if (state == S_LOAD && rx_valid) begin
        mem_addr <= idx;
        mem_wdata <= rx_data;
        idx <= idx + 1'b1;
      end
      if (state == S_FETCH) begin
        shift <= res_data;
        cnt <= '0;
        last <= res_addr == LAST;
        res_addr <= res_addr == LAST ? '0 : res_addr + 1'b1;
      end
      if (state == S_SEND && tx_ready) begin
        shift <= shift << 8;
        cnt <= cnt + 1'b1;
      end
    end
endmodule
